// File: rtl/pipelined_reduce_gate.sv
// Pipelined N-input bitwise reduction gate with a run-time bubble mask.
// Operands are reduced on sample; the AND/OR/XOR pick and inversion happen at the output stage.
module pipelined_reduce_gate #(
    parameter int NR_OF_INPUTS = 8,
    parameter int WIDTH        = 1,
    parameter int PIPE_STAGES  = 2,
    parameter logic [NR_OF_INPUTS-1:0] RESET_MASK = '0
) (
    input  logic                          Clock,
    input  logic                          Reset_n,
    input  logic                          In_Valid,
    input  logic                          Stall,
    input  logic                          Flush,
    input  logic [2:0]                    Mode,
    input  logic [NR_OF_INPUTS*WIDTH-1:0] Inputs,
    input  logic                          Mask_Load,
    input  logic [NR_OF_INPUTS-1:0]       Mask_Data,
    output logic                          Out_Valid,
    output logic [WIDTH-1:0]              Result,
    output logic [NR_OF_INPUTS-1:0]       Mask_Out
);

    localparam int LAST = PIPE_STAGES - 1;

    logic [NR_OF_INPUTS-1:0] r_mask;
    logic [WIDTH-1:0]        w_operand [NR_OF_INPUTS];
    logic [WIDTH-1:0]        w_and;
    logic [WIDTH-1:0]        w_or;
    logic [WIDTH-1:0]        w_xor;
    logic [WIDTH-1:0]        w_sel;

    logic                    r_valid [PIPE_STAGES];
    logic [2:0]              r_mode  [PIPE_STAGES];
    logic [WIDTH-1:0]        r_and   [PIPE_STAGES];
    logic [WIDTH-1:0]        r_or    [PIPE_STAGES];
    logic [WIDTH-1:0]        r_xor   [PIPE_STAGES];

    for (genvar k = 0; k < NR_OF_INPUTS; k++) begin : g_bubble
        assign w_operand[k] = Inputs[k*WIDTH +: WIDTH] ^ {WIDTH{r_mask[k]}};
    end

    always_comb begin
        w_and = '1;
        w_or  = '0;
        w_xor = '0;
        for (int k = 0; k < NR_OF_INPUTS; k++) begin
            w_and = w_and & w_operand[k];
            w_or  = w_or  | w_operand[k];
            w_xor = w_xor ^ w_operand[k];
        end
    end

    // Mask loads are independent of Stall/Flush; samples on the same edge see the old value.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            r_mask <= RESET_MASK;
        end else if (Mask_Load) begin
            r_mask <= Mask_Data;
        end
    end

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int s = 0; s < PIPE_STAGES; s++) begin
                r_valid[s] <= 1'b0;
                r_mode[s]  <= 3'b000;
                r_and[s]   <= '0;
                r_or[s]    <= '0;
                r_xor[s]   <= '0;
            end
        end else if (Flush) begin
            for (int s = 0; s < PIPE_STAGES; s++) begin
                r_valid[s] <= 1'b0;
            end
        end else if (!Stall) begin
            r_valid[0] <= In_Valid;
            r_mode[0]  <= Mode;
            r_and[0]   <= w_and;
            r_or[0]    <= w_or;
            r_xor[0]   <= w_xor;
            for (int s = 1; s < PIPE_STAGES; s++) begin
                r_valid[s] <= r_valid[s-1];
                r_mode[s]  <= r_mode[s-1];
                r_and[s]   <= r_and[s-1];
                r_or[s]    <= r_or[s-1];
                r_xor[s]   <= r_xor[s-1];
            end
        end
    end

    // Reserved modes (x11) and idle cycles both drive an all-zero result.
    always_comb begin
        w_sel  = '0;
        Result = '0;
        case (r_mode[LAST][1:0])
            2'b00:   w_sel = r_and[LAST];
            2'b01:   w_sel = r_or[LAST];
            2'b10:   w_sel = r_xor[LAST];
            default: w_sel = '0;
        endcase
        if (r_valid[LAST] && (r_mode[LAST][1:0] != 2'b11)) begin
            Result = r_mode[LAST][2] ? ~w_sel : w_sel;
        end
    end

    assign Out_Valid = r_valid[LAST];
    assign Mask_Out  = r_mask;

endmodule

// File: tb/tb_pipelined_reduce_gate.sv
// Bench for pipelined_reduce_gate: an 8x1b/2-stage instance checked every cycle against
// an index-based model plus literals, and a 3x4b/3-stage instance checked with literals.
module tb_pipelined_reduce_gate;

    logic        Clock = 1'b0;
    always #5 Clock = ~Clock;

    logic        aResetN, aInValid, aStall, aFlush, aMaskLoad;
    logic [2:0]  aMode;
    logic [7:0]  aInputs, aMaskData, aMaskOut;
    logic        aOutValid;
    logic [0:0]  aResult;

    logic        bResetN, bInValid, bMaskLoad;
    logic [2:0]  bMode, bMaskData, bMaskOut;
    logic [11:0] bInputs;
    logic        bOutValid;
    logic [3:0]  bResult;

    int vecCnt  = 0;
    int failCnt = 0;
    bit checkEn = 1'b0;

    pipelined_reduce_gate #(
        .NR_OF_INPUTS(8), .WIDTH(1), .PIPE_STAGES(2), .RESET_MASK(8'h00)
    ) dutA (
        .Clock(Clock), .Reset_n(aResetN), .In_Valid(aInValid), .Stall(aStall),
        .Flush(aFlush), .Mode(aMode), .Inputs(aInputs), .Mask_Load(aMaskLoad),
        .Mask_Data(aMaskData), .Out_Valid(aOutValid), .Result(aResult), .Mask_Out(aMaskOut)
    );

    pipelined_reduce_gate #(
        .NR_OF_INPUTS(3), .WIDTH(4), .PIPE_STAGES(3), .RESET_MASK(3'b101)
    ) dutB (
        .Clock(Clock), .Reset_n(bResetN), .In_Valid(bInValid), .Stall(1'b0),
        .Flush(1'b0), .Mode(bMode), .Inputs(bInputs), .Mask_Load(bMaskLoad),
        .Mask_Data(bMaskData), .Out_Valid(bOutValid), .Result(bResult), .Mask_Out(bMaskOut)
    );

    task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
        vecCnt++;
        if (actual !== expected) begin
            failCnt++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // Spec-level function: bubble each operand, then apply the selected reduction.
    function automatic logic reduceModel(input logic [7:0] ops, input logic [7:0] m, input logic [2:0] mode);
        logic [7:0] x;
        x = ops ^ m;
        case (mode)
            3'b000:  return &x;
            3'b001:  return |x;
            3'b010:  return ^x;
            3'b100:  return ~&x;
            3'b101:  return ~|x;
            3'b110:  return ~^x;
            default: return 1'b0;
        endcase
    endfunction

    // An op accepted on advancing edge n is visible while the advance count equals n+1.
    int         advCnt = 0;
    logic       expRes [int];
    logic [7:0] maskModel = 8'h00;

    always @(posedge Clock or negedge aResetN) begin
        if (!aResetN) begin
            expRes.delete();
            maskModel = 8'h00;
            advCnt    = 0;
        end else begin
            if (aFlush) begin
                expRes.delete();
            end else if (!aStall) begin
                advCnt++;
                if (aInValid) expRes[advCnt] = reduceModel(aInputs, maskModel, aMode);
            end
            if (aMaskLoad) maskModel = aMaskData;
        end
    end

    always @(negedge Clock) begin : compareProc
        logic expV, expR;
        if (checkEn) begin
            expV = expRes.exists(advCnt - 1);
            expR = expV ? expRes[advCnt - 1] : 1'b0;
            checkOutput("modelValid", 16'(aOutValid), 16'(expV));
            checkOutput("modelResult", 16'(aResult), 16'(expR));
            checkOutput("modelMask", 16'(aMaskOut), 16'(maskModel));
        end
    end

    task automatic applyStimulus(input logic iv, input logic st, input logic fl, input logic [2:0] mode,
                                 input logic [7:0] ins, input logic ml, input logic [7:0] md);
        aInValid = iv; aStall = st; aFlush = fl; aMode = mode;
        aInputs = ins; aMaskLoad = ml; aMaskData = md;
        @(negedge Clock);
    endtask

    task automatic applyB(input logic iv, input logic [2:0] mode, input logic [11:0] ins,
                          input logic ml, input logic [2:0] md);
        bInValid = iv; bMode = mode; bInputs = ins; bMaskLoad = ml; bMaskData = md;
        @(negedge Clock);
    endtask

    task automatic checkA(input string name, input logic expV, input logic expR);
        checkOutput({name, ".valid"}, 16'(aOutValid), 16'(expV));
        checkOutput({name, ".result"}, 16'(aResult), 16'(expR));
    endtask

    task automatic checkB(input string name, input logic expV, input logic [3:0] expR);
        checkOutput({name, ".valid"}, 16'(bOutValid), 16'(expV));
        checkOutput({name, ".result"}, 16'(bResult), 16'(expR));
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [2:0] t3Modes [6];
        logic       t3Exp   [6];
        t3Modes = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b110, 3'b011};
        t3Exp   = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};

        aResetN = 1'b1; bResetN = 1'b1;
        aInValid = 0; aStall = 0; aFlush = 0; aMode = 0; aInputs = 0; aMaskLoad = 0; aMaskData = 0;
        bInValid = 0; bMode = 0; bInputs = 0; bMaskLoad = 0; bMaskData = 0;
        #1 aResetN = 1'b0; bResetN = 1'b0;
        repeat (2) @(negedge Clock);
        checkA("reset", 1'b0, 1'b0);
        checkOutput("resetMaskA", 16'(aMaskOut), 16'h00);
        checkB("resetB", 1'b0, 4'h0);
        checkOutput("resetMaskB", 16'(bMaskOut), 16'h5);
        aResetN = 1'b1; bResetN = 1'b1;
        checkEn = 1'b1;
        @(negedge Clock);

        // NOR latency and single-cycle pulses
        applyStimulus(1, 0, 0, 3'b101, 8'h00, 0, 8'h00); checkA("t1Latency", 0, 0);
        applyStimulus(1, 0, 0, 3'b101, 8'h01, 0, 8'h00); checkA("t1Nor00", 1, 1);
        applyStimulus(0, 0, 0, 3'b000, 8'h00, 0, 8'h00); checkA("t1Nor01", 1, 0);
        applyStimulus(0, 0, 0, 3'b000, 8'h00, 0, 8'h00); checkA("t1Pulse", 0, 0);

        // Mask load on the sampling edge uses the old mask
        applyStimulus(1, 0, 0, 3'b101, 8'hFF, 1, 8'hFF);
        checkOutput("t2MaskOut", 16'(aMaskOut), 16'hFF);
        applyStimulus(1, 0, 0, 3'b101, 8'hFF, 0, 8'h00); checkA("t2OldMask", 1, 0);
        applyStimulus(0, 0, 0, 3'b000, 8'h00, 0, 8'h00); checkA("t2NewMask", 1, 1);

        // Back-to-back modes on 0xF0 (0x0F after the all-ones bubble)
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1, 0, 0, t3Modes[i], 8'hF0, 0, 8'h00);
            if (i > 0) checkA("t3BackToBack", 1, t3Exp[i-1]);
        end
        applyStimulus(0, 0, 0, 3'b000, 8'h00, 0, 8'h00); checkA("t3Last", 1, t3Exp[5]);
        applyStimulus(0, 0, 0, 3'b000, 8'h00, 0, 8'h00); checkA("t3End", 0, 0);

        // Stall with In_Valid toggling: results 0,1,0,1 in order, none extra
        applyStimulus(0, 0, 0, 3'b000, 8'h00, 1, 8'h00);
        applyStimulus(1, 0, 0, 3'b000, 8'hFE, 0, 8'h00);
        applyStimulus(1, 0, 0, 3'b001, 8'h01, 0, 8'h00); checkA("t4Op1", 1, 0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus((i != 1), 1, 0, 3'b001, 8'h80, 0, 8'h00);
            checkA("t4Frozen", 1, 0);
        end
        applyStimulus(1, 0, 0, 3'b010, 8'h03, 0, 8'h00); checkA("t4Op2", 1, 1);
        applyStimulus(1, 0, 0, 3'b010, 8'h07, 0, 8'h00); checkA("t4Op3", 1, 0);
        applyStimulus(0, 0, 0, 3'b000, 8'h00, 0, 8'h00); checkA("t4Op4", 1, 1);
        applyStimulus(0, 0, 0, 3'b000, 8'h00, 0, 8'h00); checkA("t4NoExtra", 0, 0);

        // Flush beats Stall and In_Valid; mask still loads during flush
        applyStimulus(1, 0, 0, 3'b100, 8'hFF, 0, 8'h00);
        applyStimulus(1, 0, 0, 3'b001, 8'h00, 0, 8'h00);
        applyStimulus(1, 1, 1, 3'b001, 8'h80, 1, 8'h01); checkA("t5Flush", 0, 0);
        checkOutput("t5MaskDuringFlush", 16'(aMaskOut), 16'h01);
        applyStimulus(0, 0, 0, 3'b000, 8'h00, 0, 8'h00); checkA("t5Empty1", 0, 0);
        applyStimulus(1, 0, 0, 3'b100, 8'h0F, 0, 8'h00); checkA("t5Empty2", 0, 0);
        applyStimulus(0, 0, 0, 3'b000, 8'h00, 0, 8'h00); checkA("t5AfterFlush", 1, 1);
        applyStimulus(0, 0, 0, 3'b000, 8'h00, 0, 8'h00);

        // Wide instance: XOR of 0xA, ~0x5, 0xF = 0xF with three-cycle latency
        applyB(0, 3'b000, 12'h000, 1, 3'b010);
        checkOutput("bMaskLoad", 16'(bMaskOut), 16'h2);
        applyB(1, 3'b010, 12'hF5A, 0, 3'b000); checkB("bLat1", 0, 4'h0);
        applyB(0, 3'b000, 12'h000, 0, 3'b000); checkB("bLat2", 0, 4'h0);
        applyB(0, 3'b000, 12'h000, 0, 3'b000); checkB("bXor", 1, 4'hF);
        applyB(0, 3'b000, 12'h000, 0, 3'b000); checkB("bXorDone", 0, 4'h0);

        // Mid-flight async reset drops both in-flight ops
        applyB(1, 3'b010, 12'hF5A, 0, 3'b000);
        applyB(1, 3'b110, 12'h0F0, 0, 3'b000);
        applyB(0, 3'b000, 12'h000, 0, 3'b000); checkB("bPreReset", 1, 4'hF);
        #2 bResetN = 1'b0;
        #1 checkB("bAsyncReset", 0, 4'h0);
        checkOutput("bAsyncResetMask", 16'(bMaskOut), 16'h5);
        @(negedge Clock);
        bResetN = 1'b1;
        for (int i = 0; i < 3; i++) begin
            applyB(0, 3'b000, 12'h000, 0, 3'b000);
            checkB("bNoStale", 0, 4'h0);
        end
        applyB(1, 3'b001, 12'hF5A, 0, 3'b000);
        applyB(0, 3'b000, 12'h000, 0, 3'b000);
        applyB(0, 3'b000, 12'h000, 0, 3'b000); checkB("bResetMaskOr", 1, 4'h5);

        checkEn = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vecCnt, failCnt);
        $finish;
    end

endmodule
